// File: rtl/tmeasure_sequencer_if.sv
// Sequencer <-> measurement-top link: start pulse out, busy and the packed per-range results back.
// No handshake beyond busy; results must be stable while busy is low after a measurement.
interface tmeasure_sequencer_if #(
  parameter int N_RANGE = 5,
  parameter int VAL_W   = 32
);
  logic                       meas_start;
  logic                       meas_busy;
  logic [N_RANGE*VAL_W-1:0]   meas_val;

  modport master (output meas_start, input meas_busy, input meas_val);
  modport slave  (input meas_start, output meas_busy, output meas_val);
endinterface

// File: rtl/tmeasure_sequencer.sv
// Period-measurement sequencer with autoranging; result_valid 2 cycles after busy falls.
// No backpressure: cmd_start outside IDLE is dropped, each busy phase is bounded by a watchdog.
module tmeasure_sequencer #(
  parameter int               N_RANGE        = 5,
  parameter int               VAL_W          = 32,
  parameter logic [VAL_W-1:0] SAT_LIMIT      = VAL_W'(32'h7FFF_FFFF),
  parameter logic [VAL_W-1:0] MIN_COUNT      = VAL_W'(16),
  parameter int               TIMEOUT_CYCLES = 2**24,
  parameter int               HOLDOFF_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_start,
  input  logic                   continuous,
  input  logic [HOLDOFF_W-1:0]   holdoff,
  tmeasure_sequencer_if.master   meas,
  output logic [VAL_W-1:0]       result,
  output logic [2:0]             range_sel,
  output logic                   result_valid,
  output logic                   overrange,
  output logic                   underrange,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_HI, WAIT_LO, EVAL, HOLDOFF
  } state_t;

  state_t                 state;
  logic [WD_W-1:0]        wd_cnt;
  logic [HOLDOFF_W-1:0]   hold_cnt;

  logic [2:0]             sel_idx;
  logic [VAL_W-1:0]       sel_val;
  logic                   sel_ovr;

  // Scan from the coarsest range down so the finest non-saturated one wins.
  always_comb begin
    sel_idx = 3'(N_RANGE - 1);
    sel_val = meas.meas_val[(N_RANGE-1)*VAL_W +: VAL_W];
    sel_ovr = 1'b1;
    for (int i = N_RANGE - 1; i >= 0; i--) begin
      if (meas.meas_val[i*VAL_W +: VAL_W] < SAT_LIMIT) begin
        sel_idx = 3'(i);
        sel_val = meas.meas_val[i*VAL_W +: VAL_W];
        sel_ovr = 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      hold_cnt        <= '0;
      meas.meas_start <= 1'b0;
      result          <= '0;
      range_sel       <= '0;
      result_valid    <= 1'b0;
      overrange       <= 1'b0;
      underrange      <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      meas.meas_start <= 1'b0;
      result_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            state           <= ISSUE;
            meas.meas_start <= 1'b1;
            timeout_err     <= 1'b0;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (meas.meas_busy) begin
            wd_cnt <= '0;
            state  <= WAIT_LO;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!meas.meas_busy) begin
            state <= EVAL;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        EVAL: begin
          result       <= sel_val;
          range_sel    <= sel_idx;
          overrange    <= sel_ovr;
          underrange   <= (sel_val < MIN_COUNT) && !sel_ovr;
          result_valid <= 1'b1;
          hold_cnt     <= '0;
          state        <= continuous ? HOLDOFF : IDLE;
        end
        HOLDOFF: begin
          // holdoff+1 cycles here in total, so holdoff=0 still re-issues next cycle.
          if (!continuous) begin
            state <= IDLE;
          end else if (hold_cnt >= holdoff) begin
            state           <= ISSUE;
            meas.meas_start <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
